alu_sequencer: RTL and testbench

- Bus initiator that drives the shared 32-bit datapath bus and the ALU strobes (`wr`, `rd`, `op`).
- Accepts one decoded ALU request per handshake (`op`, operand A, operand B) and runs the fixed micro-op sequence: load accumulator, execute, read back.
- Returns the result on a valid/ready response port.
- Sits between the instruction decoder and the ALU; arbitrates for the bus with a req/gnt pair.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU request sequencer.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned SRA_BIT = 10;

  localparam logic [OP_W-1:0] OP_PASS = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b1001;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b1010;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b1011;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b1100;
  localparam logic [OP_W-1:0] OP_SHR  = 4'b1101;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1110;
  localparam logic [OP_W-1:0] OP_AND  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_GNT = 3'd1,
    ST_LOAD     = 3'd2,
    ST_EXEC     = 3'd3,
    ST_READ     = 3'd4,
    ST_RESP     = 3'd5
  } alu_seq_state_t;

  // Codes 0001..0111 have no ALU meaning.
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return (op != OP_PASS) && !op[OP_W-1];
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Bus initiator running load/execute/readback on the shared ALU for one request at a time.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic              req_arith,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              alu_wr,
  output logic              alu_rd,
  output logic [OP_W-1:0]   alu_op,
  inout  wire  [DATA_W-1:0] bus
);

  alu_seq_state_t    state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              bus_req_q, bus_req_d;
  logic              alu_wr_q, alu_wr_d;
  logic              alu_rd_q, alu_rd_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              bus_oe_q, bus_oe_d;
  logic [DATA_W-1:0] bus_dout_q, bus_dout_d;

  // Next state, capture registers, and strobes decoded from the next state so they are flopped.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d = req_op;
          a_d  = req_a;
          b_d  = req_b;
          // The ALU picks sra over srl from this bit of the accumulated shift operand.
          if ((req_op == OP_SHR) && req_arith) begin
            b_d[SRA_BIT] = 1'b1;
          end
          if (op_illegal(req_op)) begin
            state_d    = ST_RESP;
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else begin
            state_d   = ST_WAIT_GNT;
            rsp_err_d = 1'b0;
          end
        end
      end
      ST_WAIT_GNT: if (bus_gnt) state_d = ST_LOAD;
      ST_LOAD:     state_d = ST_EXEC;
      ST_EXEC:     state_d = ST_READ;
      ST_READ: begin
        state_d    = ST_RESP;
        rsp_data_d = bus;
      end
      ST_RESP:     if (rsp_ready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    bus_req_d  = (state_d == ST_WAIT_GNT) || (state_d == ST_LOAD) ||
                 (state_d == ST_EXEC) || (state_d == ST_READ);
    alu_wr_d   = (state_d == ST_LOAD) || (state_d == ST_EXEC);
    alu_rd_d   = (state_d == ST_READ);
    alu_op_d   = (state_d == ST_EXEC) ? op_d : OP_PASS;
    bus_oe_d   = alu_wr_d;
    bus_dout_d = (state_d == ST_LOAD) ? b_d : a_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_PASS;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      bus_req_q  <= 1'b0;
      alu_wr_q   <= 1'b0;
      alu_rd_q   <= 1'b0;
      alu_op_q   <= OP_PASS;
      bus_oe_q   <= 1'b0;
      bus_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      bus_req_q  <= bus_req_d;
      alu_wr_q   <= alu_wr_d;
      alu_rd_q   <= alu_rd_d;
      alu_op_q   <= alu_op_d;
      bus_oe_q   <= bus_oe_d;
      bus_dout_q <= bus_dout_d;
    end
  end

  assign bus       = bus_oe_q ? bus_dout_q : {DATA_W{1'bz}};
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign bus_req   = bus_req_q;
  assign alu_wr    = alu_wr_q;
  assign alu_rd    = alu_rd_q;
  assign alu_op    = alu_op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural accumulator ALU on the shared bus.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam logic [31:0] PROBE = 32'h5A5A_C3C3;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic        req_arith = 1'b0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic        alu_wr;
  logic        alu_rd;
  logic [3:0]  alu_op;
  wire  [31:0] bus;

  logic [31:0] acc;
  logic        probe_en = 1'b0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_arith(req_arith), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .alu_wr(alu_wr), .alu_rd(alu_rd), .alu_op(alu_op), .bus(bus)
  );

  // Accumulator ALU: x comes from the bus, y is the accumulator.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r;
    case (op)
      OP_PASS: r = x;
      OP_ADD:  r = x + y;
      OP_SLL:  r = x << y[4:0];
      OP_SLT:  r = {31'd0, $signed(x) < $signed(y)};
      OP_SLTU: r = {31'd0, x < y};
      OP_XOR:  r = x ^ y;
      OP_SHR: begin
        if (y[SRA_BIT]) r = 32'($signed(x) >>> y[4:0]);
        else            r = x >> y[4:0];
      end
      OP_OR:   r = x | y;
      OP_AND:  r = x & y;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  always @(posedge clk) if (alu_wr) acc <= alu_f(alu_op, bus, acc);
  assign bus = alu_rd ? acc : (probe_en ? PROBE : 32'hzzzz_zzzz);

  // Reference result straight from the request fields.
  function automatic exp_t model(input logic [3:0] op, input logic arith,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.err  = 1'b0;
    e.data = 32'd0;
    case (op)
      OP_PASS: e.data = a;
      OP_ADD:  e.data = a + b;
      OP_SLL:  e.data = a << b[4:0];
      OP_SLT:  e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: e.data = (a < b) ? 32'd1 : 32'd0;
      OP_XOR:  e.data = a ^ b;
      OP_SHR: begin
        if (arith) e.data = 32'($signed(a) >>> b[4:0]);
        else       e.data = a >> b[4:0];
      end
      OP_OR:   e.data = a | b;
      OP_AND:  e.data = a & b;
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (edge 0); returns in cycle 0.
  task automatic send(input logic [3:0] op, input logic arith, input logic [31:0] a, input logic [31:0] b);
    req_op = op; req_arith = arith; req_a = a; req_b = b;
    req_valid = 1'b1;
    sb.push_back(model(op, arith, a, b));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n, output bit ok);
    n = 0;
    while (!rsp_valid && n < max) begin
      tick();
      n++;
    end
    ok = rsp_valid;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    probe_en = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'd0 ||
        bus_req !== 1'b0 || alu_wr !== 1'b0 || alu_rd !== 1'b0 || alu_op !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b err=%b d=%h breq=%b wr=%b rd=%b op=%h exp rdy=1 rest 0",
               req_ready, rsp_valid, rsp_err, rsp_data, bus_req, alu_wr, alu_rd, alu_op);
    end
    checks++;
    if (bus !== PROBE) begin
      errors++;
      $display("FAIL reset_bus_release got %h exp %h", bus, PROBE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    probe_en = 1'b0;
    tick();
  endtask

  task automatic test_add();
    exp_t e;
    bus_gnt = 1'b1;
    send(OP_ADD, 1'b0, 32'd5, 32'd7);
    checks++;
    if (req_ready !== 1'b0 || bus_req !== 1'b1 || alu_wr !== 1'b0) begin
      errors++;
      $display("FAIL add_wait got rdy=%b breq=%b wr=%b exp 0 1 0", req_ready, bus_req, alu_wr);
    end
    tick();
    checks++;
    if (alu_wr !== 1'b1 || alu_op !== OP_PASS || bus !== 32'd7) begin
      errors++;
      $display("FAIL add_load got wr=%b op=%h bus=%h exp 1 0 00000007", alu_wr, alu_op, bus);
    end
    tick();
    checks++;
    if (alu_wr !== 1'b1 || alu_op !== OP_ADD || bus !== 32'd5) begin
      errors++;
      $display("FAIL add_exec got wr=%b op=%h bus=%h exp 1 8 00000005", alu_wr, alu_op, bus);
    end
    tick();
    checks++;
    if (alu_rd !== 1'b1 || alu_wr !== 1'b0 || bus_req !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_read got rd=%b wr=%b breq=%b v=%b exp 1 0 1 0", alu_rd, alu_wr, bus_req, rsp_valid);
    end
    tick();
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_err !== e.err || bus_req !== 1'b0) begin
      errors++;
      $display("FAIL add_rsp got v=%b d=%h err=%b breq=%b exp v=1 d=%h err=%b breq=0",
               rsp_valid, rsp_data, rsp_err, bus_req, e.data, e.err);
    end
    ack();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_ack got v=%b rdy=%b exp 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_sra();
    exp_t e;
    int n;
    bit ok;
    for (int k = 0; k < 2; k++) begin
      send(OP_SHR, (k == 0), 32'h8000_0000, 32'd4);
      tick();
      checks++;
      if (bus !== ((k == 0) ? 32'h0000_0404 : 32'h0000_0004)) begin
        errors++;
        $display("FAIL sra_load_bus arith=%0d got %h", (k == 0), bus);
      end
      wait_valid(10, n, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || rsp_data !== e.data || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL sra_result arith=%0d got v=%b d=%h err=%b exp d=%h err=0", (k == 0), ok, rsp_data, rsp_err, e.data);
      end
      ack();
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    probe_en = 1'b1;
    send(4'b0011, 1'b0, ~PROBE, ~PROBE);
    e = sb.pop_front();
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== e.err || rsp_data !== e.data) begin
        errors++;
        $display("FAIL illegal_rsp cyc=%0d got v=%b err=%b d=%h exp v=1 err=1 d=0", c, rsp_valid, rsp_err, rsp_data);
      end
      checks++;
      if (bus_req !== 1'b0 || alu_wr !== 1'b0 || alu_rd !== 1'b0 || bus !== PROBE) begin
        errors++;
        $display("FAIL illegal_quiet cyc=%0d got breq=%b wr=%b rd=%b bus=%h", c, bus_req, alu_wr, alu_rd, bus);
      end
      if (c == 0) tick();
    end
    ack();
    probe_en = 1'b0;
  endtask

  task automatic test_gnt_stall();
    exp_t e;
    int n;
    bit ok;
    bus_gnt = 1'b0;
    probe_en = 1'b1;
    send(OP_XOR, 1'b0, 32'h1234_5678, 32'h0F0F_0F0F);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus_req !== 1'b1 || alu_wr !== 1'b0 || alu_rd !== 1'b0 || bus !== PROBE) begin
        errors++;
        $display("FAIL stall_wait cyc=%0d got breq=%b wr=%b rd=%b bus=%h", c, bus_req, alu_wr, alu_rd, bus);
      end
      if (c == 3) begin
        bus_gnt = 1'b1;
        probe_en = 1'b0;
      end
      tick();
    end
    checks++;
    if (bus !== 32'h0F0F_0F0F || alu_wr !== 1'b1) begin
      errors++;
      $display("FAIL stall_load got bus=%h wr=%b exp 0f0f0f0f 1", bus, alu_wr);
    end
    tick();
    checks++;
    if (bus !== 32'h1234_5678) begin
      errors++;
      $display("FAIL stall_exec got bus=%h exp 12345678", bus);
    end
    tick();
    checks++;
    if (bus !== 32'h1D3B_5977 || alu_rd !== 1'b1) begin
      errors++;
      $display("FAIL stall_read got bus=%h rd=%b exp 1d3b5977 1", bus, alu_rd);
    end
    wait_valid(10, n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || (n + 6) != 7 || rsp_data !== e.data) begin
      errors++;
      $display("FAIL stall_latency got v=%b cycle=%0d d=%h exp cycle 7 d=%h", ok, n + 6, rsp_data, e.data);
    end
    ack();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int n;
    bit ok;
    send(OP_OR, 1'b0, 32'hF0F0_0000, 32'h0000_FF00);
    wait_valid(10, n, ok);
    e = sb.pop_front();
    req_op = OP_ADD; req_a = 32'd1; req_b = 32'd1;
    req_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (!ok || rsp_valid !== 1'b1 || rsp_data !== e.data || req_ready !== 1'b0 || bus_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got v=%b d=%h rdy=%b breq=%b exp v=1 d=%h rdy=0 breq=0",
                 c, rsp_valid, rsp_data, req_ready, bus_req, e.data);
      end
      tick();
    end
    req_valid = 1'b0;
    ack();
    tick();
    checks++;
    if (req_ready !== 1'b1 || bus_req !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_not_taken got rdy=%b breq=%b v=%b exp 1 0 0", req_ready, bus_req, rsp_valid);
    end
  endtask

  task automatic test_reset_exec();
    exp_t e;
    int n;
    bit ok;
    send(OP_ADD, 1'b0, ~PROBE, 32'd3);
    tick();
    tick();
    rst_n = 1'b0;
    probe_en = 1'b1;
    #1;
    checks++;
    if (bus !== PROBE || alu_wr !== 1'b0 || bus_req !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_exec got bus=%h wr=%b breq=%b v=%b rdy=%b", bus, alu_wr, bus_req, rsp_valid, req_ready);
    end
    void'(sb.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    probe_en = 1'b0;
    send(OP_SLTU, 1'b0, 32'd1, 32'd2);
    wait_valid(10, n, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || n != 4 || rsp_data !== 32'd1 || rsp_data !== e.data || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_then_sltu got v=%b n=%0d d=%h err=%b exp n=4 d=00000001", ok, n, rsp_data, rsp_err);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [9];
    exp_t e;
    logic [3:0] op;
    logic [31:0] a, b;
    int n;
    bit ok;
    ops = '{OP_PASS, OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SHR, OP_OR, OP_AND};
    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(8, 0)];
      a = $urandom;
      b = $urandom;
      if (op == OP_SHR) b = b & 32'h0000_001F;
      checks++;
      if (req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready idx=%0d got %b exp 1", i, req_ready);
      end
      send(op, 1'($urandom_range(1, 0)), a, b);
      wait_valid(10, n, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || n != 4 || rsp_data !== e.data || rsp_err !== e.err) begin
        errors++;
        $display("FAIL b2b_rsp idx=%0d op=%h got v=%b n=%0d d=%h err=%b exp n=4 d=%h err=%b",
                 i, op, ok, n, rsp_data, rsp_err, e.data, e.err);
      end
      ack();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sra();
    test_illegal();
    test_gnt_stall();
    test_backpressure();
    test_reset_exec();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
